// File: rtl/seq_add_multiplier_if.sv
// Operand/result bus of the repeated-addition multiplier.
// The ovf signal exists only when SEQ_MUL_OVF_EN is defined.
interface seq_add_multiplier_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] product;
    logic             done;
    logic             busy;
`ifdef SEQ_MUL_OVF_EN
    logic             ovf;
`endif

    // Requester side: drives start and operands, observes the result
    modport master (
        output start,
        output data_in,
        input  product,
        input  done,
        input  busy
`ifdef SEQ_MUL_OVF_EN
        ,
        input  ovf
`endif
    );

    // Multiplier side
    modport slave (
        input  start,
        input  data_in,
        output product,
        output done,
        output busy
`ifdef SEQ_MUL_OVF_EN
        ,
        output ovf
`endif
    );
endinterface

// File: rtl/seq_add_multiplier.sv
// Unsigned sequential multiplier: P = A added B times, B counted down to zero.
// Operands A then B arrive on one shared bus. Product wraps modulo 2^WIDTH.
// Optional feature macro: SEQ_MUL_OVF_EN adds a sticky carry-out flag (ovf).
module seq_add_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_add_multiplier_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_CALC   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e           state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             ld_a, ld_b, clr_p, ld_p, dec_b;
    logic             eqz;
    logic [WIDTH-1:0] sum;

    // Zero detect on the down-counting multiplier
    assign eqz = (b_q == '0);

`ifdef SEQ_MUL_OVF_EN
    logic [WIDTH:0]   sum_full;
    logic             ovf_q, ovf_d;

    // Adder with carry kept for overflow tracking
    assign sum_full = {1'b0, p_q} + {1'b0, a_q};
    assign sum      = sum_full[WIDTH-1:0];
`else
    // Adder, wrap-around is silent
    assign sum      = p_q + a_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        clr_p   = 1'b0;
        ld_p    = 1'b0;
        dec_b   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                clr_p   = 1'b1;
                state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                ld_a    = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                ld_b    = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (eqz) begin
                    state_d = S_DONE;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values; at most one control per register is active in any state
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (ld_a) begin
            a_d = bus.data_in;
        end
        if (ld_b) begin
            b_d = bus.data_in;
        end else if (dec_b) begin
            b_d = b_q - WIDTH'(1);
        end
        if (clr_p) begin
            p_d = '0;
        end else if (ld_p) begin
            p_d = sum;
        end
    end

    // Status outputs are registered, decoded from the state being entered
    always_comb begin
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // Datapath and status registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

`ifdef SEQ_MUL_OVF_EN
    // Sticky overflow: cleared at the start of each run, set on any CALC carry-out
    always_comb begin
        ovf_d = ovf_q;
        if (clr_p) begin
            ovf_d = 1'b0;
        end else if (ld_p && sum_full[WIDTH]) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.product = p_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_seq_add_multiplier.sv
// Self-checking bench for seq_add_multiplier: directed corner cases plus
// randomized operands, checked against a plain-arithmetic product model.
module tb_seq_add_multiplier;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    seq_add_multiplier_if #(.WIDTH(W)) bus ();

    seq_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: unsigned product modulo 2^W and carry-out indicator
    function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] full;
        full = 32'(a) * 32'(b);
        return full[W-1:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] full;
        full = 32'(a) * 32'(b);
        return (full[31:W] != '0);
    endfunction

    // Start an operation and feed A then B; returns after the edge that captures B
    // (3 edges after the sampling edge). start is left at keep_start afterwards.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic keep_start);
        bus.start   = 1'b1;
        bus.data_in = W'($urandom);
        tick();
        bus.start = keep_start;
        check("busy_arm", 32'(bus.busy), 32'd1);
        bus.data_in = W'($urandom);
        tick();
        bus.data_in = a;
        tick();
        bus.data_in = b;
        tick();
        bus.data_in = W'($urandom);
    endtask

    // Wait (bounded) for done and check latency, product and flags
    task automatic finish(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int edges;
        edges = 3;
        check({tag, "_busy_calc"}, 32'(bus.busy), 32'd1);
        while (!bus.done && edges < 4 + int'(b) + 20) begin
            tick();
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(4 + int'(b)));
        check({tag, "_product"}, 32'(bus.product), 32'(model_prod(a, b)));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
`ifdef SEQ_MUL_OVF_EN
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(model_ovf(a, b)));
`endif
    endtask

    // Leave DONE by dropping start for one edge
    task automatic release_done();
        bus.start = 1'b0;
        tick();
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_cmp = 0;
        n_err = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;

        // Reset state
        repeat (3) tick();
        check("rst_product", 32'(bus.product), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SEQ_MUL_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);

        // Basic multiply with start held high: parks in DONE
        launch(W'(17), W'(5), 1'b1);
        finish("basic", W'(17), W'(5));
        repeat (3) tick();
        check("hold_done", 32'(bus.done), 32'd1);
        check("hold_product", 32'(bus.product), 32'd85);
        release_done();
        check("idle_after_done", 32'(bus.done), 32'd0);
        check("idle_product_held", 32'(bus.product), 32'd85);

        // Zero multiplier and zero multiplicand
        launch(W'(1234), W'(0), 1'b0);
        finish("zero_b", W'(1234), W'(0));
        release_done();
        launch(W'(0), W'(3), 1'b0);
        finish("zero_a", W'(0), W'(3));
        release_done();

        // Wrap-around
        launch(W'(16'h8000), W'(3), 1'b0);
        finish("wrap", W'(16'h8000), W'(3));
        release_done();

        // Back-to-back after one cycle with start low; ovf must clear
        launch(W'(7), W'(6), 1'b0);
        finish("b2b", W'(7), W'(6));
        release_done();

        // Randomized operations with random idle gaps
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 40));
            if (i % 4 == 0) ra = W'($urandom_range(0, 255));
            launch(ra, rb, 1'($urandom_range(0, 1)));
            finish("rand", ra, rb);
            release_done();
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset in the middle of CALC aborts immediately
        launch(W'(17), W'(5), 1'b0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_product", 32'(bus.product), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        launch(W'(3), W'(4), 1'b0);
        finish("after_rst", W'(3), W'(4));
        release_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
